xbar_fifo_router: RTL and testbench

Parametrised CH×CH FIFO crossbar, successor to the fixed 4-input/4-output FIFO system. Words enter per-channel input FIFOs and are routed by their top destination bits through a single arbitrated transfer path into per-channel output FIFOs. Routing is throttled by programmable high/low thresholds. A control FSM (RESET/INIT/IDLE/ACTIVE/ERROR) and a per-output delivered-word counter, read out in IDLE through a req/idx handshake, complete the block.

---
 rtl/xbar_fifo_router.sv | 247 ++++++++++++++++++++++++
 tb/tb_xbar_fifo_router.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_fifo_router.sv
// xbar_fifo_router: CH x CH FIFO crossbar. Per-input FIFOs feed one arbitrated
// transfer path into per-output FIFOs, throttled by high/low thresholds, with a
// RESET/INIT/IDLE/ACTIVE/ERROR control FSM and per-output delivered-word counters.
// Optional feature macro: ROUND_ROBIN_EN (rotating grant; default is fixed priority).

// Single show-ahead FIFO used for every input and output lane.
module xbar_fifo #(
    parameter int DW    = 10,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    output logic [DW-1:0] head,
    output logic [AW:0]   count
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    // Storage carries no reset; emptiness is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (wr) r_mem[r_wp] <= wdata;
    end

    // Pointer and occupancy bookkeeping; callers only assert wr/rd when legal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (wr) r_wp <= r_wp + AW'(1);
            if (rd) r_rp <= r_rp + AW'(1);
            case ({wr, rd})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign head  = (r_cnt != '0) ? r_mem[r_rp] : '0;
    assign count = r_cnt;
endmodule

module xbar_fifo_router #(
    parameter  int CH    = 4,
    parameter  int DW    = 10,
    parameter  int DEPTH = 8,
    parameter  int CW    = 5,
    localparam int DB    = $clog2(CH),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic [AW:0]        umbral_alto,
    input  logic [AW:0]        umbral_bajo,
    input  logic [CH-1:0]      push,
    input  logic [CH*DW-1:0]   data_in,
    input  logic [CH-1:0]      pop,
    output logic [CH*DW-1:0]   data_out,
    output logic [CH-1:0]      empty_out,
    output logic [CH-1:0]      almost_full_out,
    output logic [CH-1:0]      almost_empty_out,
    output logic [CH-1:0]      full_in,
    output logic [2:0]         state,
    output logic               idle,
    output logic               error,
    input  logic               req,
    input  logic [DB-1:0]      idx,
    output logic               valid_cnt,
    output logic [CW-1:0]      cnt_out
);
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t                  r_state, w_nxt;
    logic [AW:0]             r_alto, r_bajo;
    logic [CH-1:0][CW-1:0]   r_cnt;
    logic                    r_valid;
    logic [CW-1:0]           r_cnt_out;

    logic [CH-1:0][DW-1:0]   w_in_head;
    logic [CH-1:0][AW:0]     w_in_cnt;
    logic [CH-1:0][AW:0]     w_out_cnt;
    logic [CH-1:0][DB-1:0]   w_in_dst;
    logic [CH-1:0]           w_elig, w_in_rd, w_in_wr, w_in_ne, w_ovf_vec;
    logic [CH-1:0]           w_out_wr, w_out_rd;
    logic                    w_gnt_vld;
    logic [DB-1:0]           w_gnt_idx;
    logic [DW-1:0]           w_xfer_data;
    logic [DB-1:0]           w_xfer_dst;
    logic [AW:0]             w_alto_eff;
    logic                    w_xfer_ok, w_busy, w_ovf;

    // A high threshold above DEPTH saturates at DEPTH.
    assign w_alto_eff  = (r_alto > FULL) ? FULL : r_alto;
    assign w_xfer_ok   = (r_state == S_IDLE) || (r_state == S_ACTIVE) || (r_state == S_ERROR);
    assign w_xfer_data = w_in_head[w_gnt_idx];
    assign w_xfer_dst  = w_xfer_data[DW-1 -: DB];
    assign w_busy      = (|w_in_ne) || (|(~empty_out));
    assign w_ovf       = |w_ovf_vec;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        xbar_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_in (
            .clk   (clk),
            .rst_n (reset),
            .wr    (w_in_wr[g]),
            .wdata (data_in[g*DW +: DW]),
            .rd    (w_in_rd[g]),
            .head  (w_in_head[g]),
            .count (w_in_cnt[g])
        );
        xbar_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_out (
            .clk   (clk),
            .rst_n (reset),
            .wr    (w_out_wr[g]),
            .wdata (w_xfer_data),
            .rd    (w_out_rd[g]),
            .head  (data_out[g*DW +: DW]),
            .count (w_out_cnt[g])
        );
        assign w_in_dst[g]  = w_in_head[g][DW-1 -: DB];
        assign w_in_ne[g]   = (w_in_cnt[g] != '0);
        assign w_elig[g]    = w_xfer_ok && w_in_ne[g] &&
                              (w_out_cnt[w_in_dst[g]] < w_alto_eff) &&
                              (w_out_cnt[w_in_dst[g]] != FULL);
        assign w_in_rd[g]   = w_gnt_vld && (w_gnt_idx == DB'(g));
        // A full input still accepts a push when its head leaves this cycle.
        assign w_in_wr[g]   = push[g] && ((w_in_cnt[g] != FULL) || w_in_rd[g]);
        assign w_ovf_vec[g] = push[g] && (w_in_cnt[g] == FULL) && !w_in_rd[g];
        assign w_out_wr[g]  = w_gnt_vld && (w_xfer_dst == DB'(g));
        assign w_out_rd[g]  = pop[g] && (w_out_cnt[g] != '0);
        assign empty_out[g]        = (w_out_cnt[g] == '0);
        assign full_in[g]          = (w_in_cnt[g] == FULL);
        assign almost_full_out[g]  = (w_out_cnt[g] >= w_alto_eff);
        assign almost_empty_out[g] = (w_out_cnt[g] <= r_bajo);
    end

`ifdef ROUND_ROBIN_EN
    logic [DB-1:0] r_last;
    logic [DB-1:0] w_cand;

    // Rotating grant: scan from last+CH down to last+1 so the lowest offset wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = CH; k >= 1; k--) begin
            w_cand = r_last + DB'(k);
            if (w_elig[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    // Last-granted pointer starts at CH-1 so the first search begins at input 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         r_last <= DB'(CH-1);
        else if (w_gnt_vld) r_last <= w_gnt_idx;
    end
`else
    // Fixed priority: the lowest eligible input index wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = CH-1; k >= 0; k--) begin
            if (w_elig[k]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = DB'(k);
            end
        end
    end
`endif

    // Control FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_RESET;
        else        r_state <= w_nxt;
    end

    // Next-state logic; an overflow in any state forces ERROR.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_RESET:  w_nxt = S_INIT;
            S_INIT:   if (!init) w_nxt = S_IDLE;
            S_IDLE:   if (init) w_nxt = S_INIT; else if (w_busy) w_nxt = S_ACTIVE;
            S_ACTIVE: if (init) w_nxt = S_INIT; else if (!w_busy) w_nxt = S_IDLE;
            S_ERROR:  w_nxt = S_ERROR;
            default:  w_nxt = S_RESET;
        endcase
        if (w_ovf) w_nxt = S_ERROR;
    end

    // Thresholds track the inputs for every cycle spent in INIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alto <= FULL;
            r_bajo <= '0;
        end else if (r_state == S_INIT) begin
            r_alto <= umbral_alto;
            r_bajo <= umbral_bajo;
        end
    end

    // Delivered-word counters, wrapping modulo 2^CW.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            for (int j = 0; j < CH; j++)
                if (w_out_rd[j]) r_cnt[j] <= r_cnt[j] + CW'(1);
        end
    end

    // Counter readout: one-cycle response, only honoured in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_cnt_out <= '0;
        end else begin
            r_valid   <= req && (r_state == S_IDLE);
            r_cnt_out <= (req && (r_state == S_IDLE)) ? r_cnt[idx] : '0;
        end
    end

    assign state     = r_state;
    assign idle      = (r_state == S_IDLE);
    assign error     = (r_state == S_ERROR);
    assign valid_cnt = r_valid;
    assign cnt_out   = r_cnt_out;
endmodule

// File: tb/tb_xbar_fifo_router.sv
// Scoreboard bench for xbar_fifo_router: stimulus queues expected output words
// and counter reads; a negedge monitor compares whenever the DUT delivers.
module tb_xbar_fifo_router;
    localparam int CH = 4, DW = 10, DEPTH = 8, CW = 5, AW = 3, DB = 2;

    logic              clk = 1'b0;
    logic              reset, init, req;
    logic [AW:0]       umbral_alto, umbral_bajo;
    logic [CH-1:0]     push, pop;
    logic [CH*DW-1:0]  data_in;
    logic [CH*DW-1:0]  data_out;
    logic [CH-1:0]     empty_out, almost_full_out, almost_empty_out, full_in;
    logic [2:0]        state;
    logic              idle, error, valid_cnt;
    logic [DB-1:0]     idx;
    logic [CW-1:0]     cnt_out;

    int n_chk  = 0;
    int n_pass = 0;
    logic [DW-1:0] q_data[$];
    logic [CW-1:0] q_cnt[$];

    xbar_fifo_router #(.CH(CH), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
        .push(push), .data_in(data_in), .pop(pop), .data_out(data_out),
        .empty_out(empty_out), .almost_full_out(almost_full_out),
        .almost_empty_out(almost_empty_out), .full_in(full_in),
        .state(state), .idle(idle), .error(error),
        .req(req), .idx(idx), .valid_cnt(valid_cnt), .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(int ch, logic [DW-1:0] w);
        data_in[ch*DW +: DW] = w;
    endtask

    task automatic read_cnt(logic [DB-1:0] i, logic [CW-1:0] exp);
        req = 1'b1;
        idx = i;
        q_cnt.push_back(exp);
        tick();
        req = 1'b0;
        tick();
    endtask

    // Monitor: every accepted pop and every valid counter response is scored.
    initial begin
        logic [DW-1:0] ew;
        logic [CW-1:0] ec;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                for (int j = 0; j < CH; j++) begin
                    if (pop[j] && !empty_out[j]) begin
                        if (q_data.size() == 0) begin
                            check($sformatf("unexpected_pop%0d", j), 32'(data_out[j*DW +: DW]), 32'hFFFF_FFFF);
                        end else begin
                            ew = q_data.pop_front();
                            check($sformatf("data_out%0d", j), 32'(data_out[j*DW +: DW]), 32'(ew));
                        end
                    end
                end
                if (valid_cnt) begin
                    if (q_cnt.size() == 0) begin
                        check("unexpected_valid_cnt", 32'(cnt_out), 32'hFFFF_FFFF);
                    end else begin
                        ec = q_cnt.pop_front();
                        check("cnt_out", 32'(cnt_out), 32'(ec));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; init = 1'b0; req = 1'b0; idx = '0;
        umbral_alto = '0; umbral_bajo = '0;
        push = '0; pop = '0; data_in = '0;
        #12;
        check("rst_state", 32'(state), 32'd0);
        check("rst_empty_out", 32'(empty_out), 32'hF);
        check("rst_full_in", 32'(full_in), 32'h0);
        check("rst_almost_empty", 32'(almost_empty_out), 32'hF);
        check("rst_almost_full", 32'(almost_full_out), 32'h0);
        check("rst_valid_cnt", 32'(valid_cnt), 32'd0);
        check("rst_cnt_out", 32'(cnt_out), 32'd0);
        check("rst_data_out", 32'(data_out == '0), 32'd1);

        // Release reset and program alto=3, bajo=1.
        tick();
        reset = 1'b1; init = 1'b1; umbral_alto = 4'd3; umbral_bajo = 4'd1;
        tick();
        check("state_init", 32'(state), 32'd1);
        tick();
        check("state_init_hold", 32'(state), 32'd1);
        init = 1'b0;
        tick();
        check("state_idle", 32'(state), 32'd2);
        check("idle_flag", 32'(idle), 32'd1);

        // Burst 1: all inputs to output 3 at once; order 0,1,2,3 in either mode.
        for (int i = 0; i < CH; i++) begin
            set_word(i, DW'(10'h3A0 + i));
            q_data.push_back(DW'(10'h3A0 + i));
        end
        push = 4'hF;
        tick();
        push = '0; pop = 4'b1000;
        repeat (8) tick();
        pop = '0;
        tick();
        check("burst1_idle", 32'(state), 32'd2);

        // Burst 2: input 0 refilled one cycle later.
        for (int i = 0; i < CH; i++) set_word(i, DW'(10'h3B0 + i));
`ifdef ROUND_ROBIN_EN
        q_data.push_back(10'h3B0); q_data.push_back(10'h3B1); q_data.push_back(10'h3B2);
        q_data.push_back(10'h3B3); q_data.push_back(10'h3B4);
`else
        q_data.push_back(10'h3B0); q_data.push_back(10'h3B4); q_data.push_back(10'h3B1);
        q_data.push_back(10'h3B2); q_data.push_back(10'h3B3);
`endif
        push = 4'hF;
        tick();
        push = 4'b0001; set_word(0, 10'h3B4); pop = 4'b1000;
        tick();
        push = '0;
        repeat (8) tick();
        pop = '0;
        tick();
        check("burst2_idle", 32'(state), 32'd2);
        read_cnt(2'd3, 5'd9);

        // Threshold stall: 5 words into output 0 with alto=3.
        for (int k = 0; k < 5; k++) begin
            push = 4'b0001;
            set_word(0, DW'(10'h011 + k));
            q_data.push_back(DW'(10'h011 + k));
            tick();
        end
        push = '0;
        repeat (5) tick();
        check("stall_almost_full", 32'(almost_full_out), 32'b0001);
        check("stall_almost_empty", 32'(almost_empty_out), 32'b1110);
        check("stall_head", 32'(data_out[DW-1:0]), 32'h011);
        check("stall_full_in", 32'(full_in), 32'h0);
        check("stall_active", 32'(state), 32'd3);
        pop = 4'b0001;
        repeat (5) tick();
        pop = '0;
        tick();
        check("stall_drained_idle", 32'(state), 32'd2);
        check("stall_drained_empty", 32'(empty_out), 32'hF);
        read_cnt(2'd0, 5'd5);

        // Seven words through output 1, then counter read in IDLE.
        pop = 4'b0010;
        for (int k = 0; k < 7; k++) begin
            push = 4'b0010;
            set_word(1, DW'(10'h100 + k));
            q_data.push_back(DW'(10'h100 + k));
            tick();
        end
        push = '0;
        repeat (4) tick();
        pop = '0;
        tick();
        check("out1_idle", 32'(state), 32'd2);
        read_cnt(2'd1, 5'd7);

        // Same request while ACTIVE is refused.
        push = 4'b0010; set_word(1, 10'h1F0); q_data.push_back(10'h1F0);
        tick();
        push = '0;
        tick();
        check("req_active_state", 32'(state), 32'd3);
        req = 1'b1; idx = 2'd1;
        tick();
        req = 1'b0;
        check("req_active_valid", 32'(valid_cnt), 32'd0);
        check("req_active_cnt", 32'(cnt_out), 32'd0);

        // 27 more pops on output 1: 34 total wraps the 5-bit counter to 2.
        pop = 4'b0010;
        for (int k = 0; k < 26; k++) begin
            push = 4'b0010;
            set_word(1, DW'(10'h120 + k));
            q_data.push_back(DW'(10'h120 + k));
            tick();
        end
        push = '0;
        repeat (4) tick();
        pop = '0;
        tick();
        check("wrap_idle", 32'(state), 32'd2);
        read_cnt(2'd1, 5'd2);

        // Overflow: alto=0 blocks transfers, 9th push to input 2 drops.
        init = 1'b1; umbral_alto = '0; umbral_bajo = '0;
        tick();
        check("reinit_state", 32'(state), 32'd1);
        init = 1'b0;
        tick();
        check("reinit_idle", 32'(state), 32'd2);
        check("alto0_almost_full", 32'(almost_full_out), 32'hF);
        for (int k = 0; k < 8; k++) begin
            push = 4'b0100;
            set_word(2, DW'(10'h200 + k));
            tick();
        end
        check("ovf_full_in", 32'(full_in), 32'b0100);
        check("ovf_pre_state", 32'(state), 32'd3);
        set_word(2, 10'h2FF);
        tick();
        push = '0;
        check("ovf_state", 32'(state), 32'd4);
        check("ovf_error", 32'(error), 32'd1);
        tick();
        check("ovf_sticky", 32'(state), 32'd4);
        check("ovf_no_xfer", 32'(empty_out), 32'hF);
        reset = 1'b0;
        #1;
        check("rst2_state", 32'(state), 32'd0);
        check("rst2_full_in", 32'(full_in), 32'h0);
        check("rst2_error", 32'(error), 32'd0);

        check("sb_data_left", 32'(q_data.size()), 32'd0);
        check("sb_cnt_left", 32'(q_cnt.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
